serializer_stream: RTL and testbench
====================================

// Module: serializer_stream
// PURPOSE
//  Parametrised successor of the Lab 1 serializer: converts DATA_W-bit words of runtime length into
//  a serial bit stream. Adds ready/valid on both sides, a one-word holding buffer for gapless
//  back-to-back words, per-word MSB/LSB-first order and explicit dropping of too-short words.
//  Sits between a word producer (e.g. packet/stimulus logic) and a bit-serial consumer.
// PARAMETERS
//  DATA_W   16  word width; power of two, >= 4
//  MIN_LEN  3   shortest word length sent; words with length 1..MIN_LEN-1 are dropped
//  MOD_W    $clog2(DATA_W)  width of data_mod_i (derived; do not override)
// PORTS
//  clk_i           in   1        clock; all logic on posedge
//  arst_n_i        in   1        reset, asynchronous, active-low
//  data_i          in   DATA_W   word to serialize
//  data_mod_i      in   MOD_W    word length L; 0 means L = DATA_W
//  msb_first_i     in   1        1: send data_i[DATA_W-1] downward; 0: send data_i[0] upward
//  data_val_i      in   1        word valid
//  data_rdy_o      out  1        word accepted on edge where data_val_i & data_rdy_o
//  ser_data_o      out  1        serial bit
//  ser_data_val_o  out  1        ser_data_o valid
//  ser_rdy_i       in   1        bit transferred on edge where ser_data_val_o & ser_rdy_i
//  busy_o          out  1        shifter active or holding buffer full
//  drop_o          out  1        1-cycle pulse: accepted word discarded (L < MIN_LEN)
// BEHAVIOUR
//  Reset: async clear; ser_data_o=0, ser_data_val_o=0, busy_o=0, drop_o=0, hold empty,
//   data_rdy_o=1. Partial word in flight and held word are lost; nothing is resumed after release.
//  Storage: shift register SR + bit counter REM (MOD_W+1 bits) + holding reg HOLD {data,L,order,full}.
//  FSM: IDLE (REM==0) / SHIFT (REM!=0). ser_data_val_o = (state==SHIFT). Outputs come from flops only.
//  ser_data_o = order ? SR[DATA_W-1] : SR[0]. Each transfer shifts SR toward the output end and
//   decrements REM. SHIFT->IDLE when the bit with REM==1 transfers and no next word is available.
//  data_rdy_o = !HOLD.full (no combinational path from ser_rdy_i).
//  On accept, L computed with MOD_W+1-bit arithmetic (0 -> DATA_W):
//   - L < MIN_LEN: word discarded, drop_o=1 next cycle, SR/HOLD untouched.
//   - shifter IDLE, or last bit transferring this edge, and HOLD empty: load SR directly, REM=L.
//   - otherwise: write HOLD; busy_o stays 1.
//  When the last bit transfers and HOLD.full: HOLD->SR on the same edge, HOLD.full=0.
//   No idle cycle between words while ser_rdy_i=1.
//  Latency: word accepted at edge N while IDLE -> first bit presented, ser_data_val_o=1, after N.
//  Order and L are latched per word; msb_first_i/data_mod_i changes affect only later accepts.
//  ser_rdy_i=0: SR, REM, ser_data_o, ser_data_val_o hold; an upstream accept into HOLD still occurs.
//  busy_o = (state==SHIFT) | HOLD.full, registered with the state it reflects.
//  data_i bits beyond L are ignored; width of data_i does not constrain L beyond DATA_W.
// TESTING (DATA_W=16, MIN_LEN=3)
//  1 data_i=16'hA5C3, mod=0, msb=1, ser_rdy=1 -> 16 val cycles, bits 1010010111000011,
//    val starts the cycle after accept, then busy_o=0.
//  2 data_i=16'h0013, mod=5, msb=0 -> bits 1,1,0,0,1 then val=0. Same word with msb=1 ->
//    bits 0,0,0,0,0.
//  3 mod=2 with val=1 -> accepted, drop_o pulses once, ser_data_val_o stays 0, busy_o stays 0.
//  4 three words (mod=4,4,4) with data_val_i held 1 -> rdy falls after 2nd accept, 12 contiguous
//    val cycles, no gap between words.
//  5 ser_rdy_i=0 for 3 cycles mid-word -> ser_data_o/val frozen, no bit lost or repeated.
//  6 arst_n_i low mid-word (async, off-edge) -> outputs 0 immediately; after release rdy=1 and
//    the next word is sent complete.

Source files
------------

// File: rtl/serializer_stream.sv
// Word-to-bit serializer with ready/valid on both sides, a one-word holding buffer for
// gapless back-to-back words, per-word bit order and dropping of too-short words.
module serializer_stream #(
  parameter int DATA_W  = 16,
  parameter int MIN_LEN = 3,
  parameter int MOD_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  input  logic              ser_rdy_i,
  output logic              busy_o,
  output logic              drop_o
);
  localparam int LW = MOD_W + 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic              ord_q, ord_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [LW-1:0]     hold_len_q, hold_len_d;
  logic              hold_ord_q, hold_ord_d;
  logic              hold_full_q, hold_full_d;
  logic              drop_q, drop_d;

  logic [LW-1:0] len;
  logic          accept, too_short, xfer, last, direct, to_hold;

  // Length 0 encodes a full-width word; compare in MOD_W+1 bits so DATA_W fits.
  assign len       = (data_mod_i == '0) ? LW'(DATA_W) : {1'b0, data_mod_i};
  assign too_short = len < LW'(MIN_LEN);
  assign accept    = data_val_i & ~hold_full_q;
  assign xfer      = (state_q == SHIFT) & ser_rdy_i;
  assign last      = xfer & (rem_q == LW'(1));
  assign direct    = accept & ~too_short & ((state_q == IDLE) | last);
  assign to_hold   = accept & ~too_short & ~direct;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      rem_q       <= '0;
      ord_q       <= 1'b0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_ord_q  <= 1'b0;
      hold_full_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rem_q       <= rem_d;
      ord_q       <= ord_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_ord_q  <= hold_ord_d;
      hold_full_q <= hold_full_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    sr_d        = sr_q;
    rem_d       = rem_q;
    ord_d       = ord_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_ord_d  = hold_ord_q;
    hold_full_d = hold_full_q;
    drop_d      = accept & too_short;
    // A direct load can never coincide with a HOLD refill: direct needs HOLD empty.
    if (direct) begin
      sr_d  = data_i;
      rem_d = len;
      ord_d = msb_first_i;
    end else if (last && hold_full_q) begin
      sr_d        = hold_data_q;
      rem_d       = hold_len_q;
      ord_d       = hold_ord_q;
      hold_full_d = 1'b0;
    end else if (xfer) begin
      sr_d  = ord_q ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
      rem_d = rem_q - LW'(1);
    end
    if (to_hold) begin
      hold_data_d = data_i;
      hold_len_d  = len;
      hold_ord_d  = msb_first_i;
      hold_full_d = 1'b1;
    end
    state_d = (rem_d != '0) ? SHIFT : IDLE;
  end

  always_comb begin
    ser_data_val_o = (state_q == SHIFT);
    ser_data_o     = ord_q ? sr_q[DATA_W-1] : sr_q[0];
    busy_o         = (state_q == SHIFT) | hold_full_q;
    data_rdy_o     = ~hold_full_q;
    drop_o         = drop_q;
  end
endmodule

// File: tb/tb_serializer_stream.sv
// Directed bench for serializer_stream (DATA_W=16, MIN_LEN=3) with hand-computed bit streams.
`timescale 1ns/1ps
module tb_serializer_stream;
  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              gclk = 1'b0;
  logic              arst_n;
  logic [DATA_W-1:0] data;
  logic [MOD_W-1:0]  data_mod;
  logic              msb_first, data_val, data_rdy;
  logic              ser_data, ser_val, ser_rdy, busy, drop;

  int n_chk = 0;
  int n_err = 0;

  serializer_stream #(.DATA_W(DATA_W), .MIN_LEN(3)) dut (
    .clk_i(gclk), .arst_n_i(arst_n), .data_i(data), .data_mod_i(data_mod),
    .msb_first_i(msb_first), .data_val_i(data_val), .data_rdy_o(data_rdy),
    .ser_data_o(ser_data), .ser_data_val_o(ser_val), .ser_rdy_i(ser_rdy),
    .busy_o(busy), .drop_o(drop)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Present one word for a single edge; afterwards scramble order/length to prove they were latched.
  task automatic accept_word(input logic [15:0] d, input logic [3:0] m, input logic msb);
    chk("acc_rdy", 32'(data_rdy), 32'd1);
    data = d; data_mod = m; msb_first = msb; data_val = 1'b1;
    tick();
    data_val = 1'b0; msb_first = ~msb; data_mod = 4'd7; data = 16'hFFFF;
  endtask

  // Expects bits exp[n-1] first; optional ser_rdy stall before bit stall_at is transferred.
  task automatic stream(input string tag, input logic [31:0] exp, input int n,
                        input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"}, 32'(ser_val), 32'd1);
      chk({tag, "_bit"}, 32'(ser_data), 32'(exp[n-1-i]));
      if (i == stall_at) begin
        ser_rdy = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk({tag, "_stall_val"}, 32'(ser_val), 32'd1);
          chk({tag, "_stall_bit"}, 32'(ser_data), 32'(exp[n-1-i]));
        end
        ser_rdy = 1'b1;
      end
      tick();
    end
    chk({tag, "_end_val"}, 32'(ser_val), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] words [3];
    logic [11:0] exp4;
    logic        vals [16];
    logic        bits [16];
    logic        rdy_after [16];
    int          k;
    logic        acc;

    arst_n = 1'b0; data = '0; data_mod = '0; msb_first = 1'b0; data_val = 1'b0; ser_rdy = 1'b1;
    #12;
    chk("rst_val", 32'(ser_val), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_rdy", 32'(data_rdy), 32'd1);
    #1 arst_n = 1'b1;
    tick();

    // 1: full-width word MSB first; valid starts the cycle after accept
    chk("t1_pre_val", 32'(ser_val), 32'd0);
    accept_word(16'hA5C3, 4'd0, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    stream("t1", 32'h0000A5C3, 16, -1, 0);

    // 2: 5-bit word, both orders
    accept_word(16'h0013, 4'd5, 1'b0);
    stream("t2_lsb", 32'b11001, 5, -1, 0);
    accept_word(16'h0013, 4'd5, 1'b1);
    stream("t2_msb", 32'b00000, 5, -1, 0);

    // 3: too-short word is dropped
    accept_word(16'hFFFF, 4'd2, 1'b1);
    chk("t3_drop", 32'(drop), 32'd1);
    chk("t3_val", 32'(ser_val), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_drop_off", 32'(drop), 32'd0);
    chk("t3_val2", 32'(ser_val), 32'd0);
    chk("t3_busy2", 32'(busy), 32'd0);

    // 4: three 4-bit words with valid held; expect 12 contiguous bits A,5,C
    words[0] = 16'hA000; words[1] = 16'h5000; words[2] = 16'hC000;
    exp4 = 12'hA5C;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (k < 3) begin
        data_val = 1'b1; data = words[k]; data_mod = 4'd4; msb_first = 1'b1;
      end else begin
        data_val = 1'b0;
      end
      acc = (k < 3) && data_rdy;
      tick();
      if (acc) k++;
      vals[c] = ser_val; bits[c] = ser_data; rdy_after[c] = data_rdy;
    end
    chk("t4_all_accepted", 32'(k), 32'd3);
    chk("t4_rdy_after_2nd", 32'(rdy_after[1]), 32'd0);
    for (int c = 0; c < 12; c++) begin
      chk("t4_val", 32'(vals[c]), 32'd1);
      chk("t4_bit", 32'(bits[c]), 32'(exp4[11-c]));
    end
    chk("t4_end_val", 32'(vals[12]), 32'd0);
    chk("t4_end_busy", 32'(busy), 32'd0);

    // 5: backpressure mid-word
    accept_word(16'hA5C3, 4'd0, 1'b1);
    stream("t5", 32'h0000A5C3, 16, 5, 3);

    // 6: async reset mid-word, then a full word afterwards
    accept_word(16'hA5C3, 4'd0, 1'b1);
    tick(); tick();
    chk("t6_mid_val", 32'(ser_val), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_rst_val", 32'(ser_val), 32'd0);
    chk("t6_rst_data", 32'(ser_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rdy", 32'(data_rdy), 32'd1);
    #10 arst_n = 1'b1;
    tick();
    chk("t6_post_val", 32'(ser_val), 32'd0);
    chk("t6_post_rdy", 32'(data_rdy), 32'd1);
    accept_word(16'h0013, 4'd5, 1'b0);
    stream("t6", 32'b11001, 5, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
